// File: rtl/queue_counter_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : queue_counter_param_if
//  Purpose  : Bundles the button inputs, clear and status outputs of the
//             BBqM occupancy counter.
//  Ports    : (interface signals)
//             Up, Down, Clear      - raw buttons and synchronous clear
//             Pcount               - current occupancy (CNT_W bits)
//             Empty_Flag, Full_Flag, Almost_Full_Flag - occupancy decodes
//             Alarm_Flag, Underflow_Flag             - sticky alarms
//             Up_Pulse, Down_Pulse                   - accepted-press pulses
//  Modports : master (drives buttons, reads status), slave (the counter)
//  Revision : 1.0 - initial release
// ============================================================================
interface queue_counter_param_if #(
  parameter int CNT_W = 3
) ();
  logic             Up;
  logic             Down;
  logic             Clear;
  logic [CNT_W-1:0] Pcount;
  logic             Empty_Flag;
  logic             Full_Flag;
  logic             Almost_Full_Flag;
  logic             Alarm_Flag;
  logic             Underflow_Flag;
  logic             Up_Pulse;
  logic             Down_Pulse;

  modport master (
    output Up, Down, Clear,
    input  Pcount, Empty_Flag, Full_Flag, Almost_Full_Flag,
    input  Alarm_Flag, Underflow_Flag, Up_Pulse, Down_Pulse
  );

  modport slave (
    input  Up, Down, Clear,
    output Pcount, Empty_Flag, Full_Flag, Almost_Full_Flag,
    output Alarm_Flag, Underflow_Flag, Up_Pulse, Down_Pulse
  );
endinterface
`default_nettype wire

// File: rtl/queue_counter_param.sv
`default_nettype none
// ============================================================================
//  Module   : queue_counter_param
//  Purpose  : Single-clock occupancy counter for the BBqM queue manager.
//             Each push button is synchronised, debounced on a sampling tick
//             and edge-detected into a one-cycle pulse; the pulses move a
//             saturating counter with sticky overflow/underflow alarms.
//  Ports    : CLK   - system clock
//             reset - asynchronous active-low reset
//             bus   - queue_counter_param_if.slave (buttons, clear, status)
//  Revision : 1.0 - initial release
// ============================================================================
module queue_counter_param #(
  parameter int CNT_W       = 3,
  parameter int MAX_COUNT   = 7,
  parameter int ALMOST_FULL = 6,
  parameter int TICK_DIV    = 500000,
  parameter int DEB_TICKS   = 4
) (
  input  wire logic                  CLK,
  input  wire logic                  reset,
  queue_counter_param_if.slave       bus
);

  localparam int DIV_W  = $clog2(TICK_DIV);
  localparam int STAB_W = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEB_TICKS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0]  CNT_AF    = CNT_W'(ALMOST_FULL);

  // --------------------------------------------------------------------------
  // Sampling tick: one-cycle enable every TICK_DIV clocks
  // --------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Per-button conditioning: bit 0 = Up, bit 1 = Down
  // --------------------------------------------------------------------------
  logic [1:0] raw_btn;
  logic [1:0] btn_pulse;

  assign raw_btn = {bus.Down, bus.Up};

  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic              sync1;
    logic              sync2;
    logic              level;
    logic              level_d;
    logic              pulse_r;
    logic [STAB_W-1:0] stab_cnt;

    always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
        sync1    <= 1'b0;
        sync2    <= 1'b0;
        level    <= 1'b0;
        level_d  <= 1'b0;
        pulse_r  <= 1'b0;
        stab_cnt <= '0;
      end else begin
        sync1   <= raw_btn[i];
        sync2   <= sync1;
        level_d <= level;
        // Registered rising-edge detect: high the cycle after level rises.
        pulse_r <= level & ~level_d;
        if (tick) begin
          if (sync2 == level) begin
            stab_cnt <= '0;
          end else if (stab_cnt == STAB_LAST) begin
            level    <= sync2;
            stab_cnt <= '0;
          end else begin
            stab_cnt <= stab_cnt + STAB_W'(1);
          end
        end
      end
    end

    assign btn_pulse[i] = pulse_r;
  end

  // --------------------------------------------------------------------------
  // Saturating occupancy counter with sticky alarms
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] pcount;
  logic             alarm;
  logic             underflow;
  logic             up_p;
  logic             dn_p;

  assign up_p = btn_pulse[0];
  assign dn_p = btn_pulse[1];

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      pcount    <= '0;
      alarm     <= 1'b0;
      underflow <= 1'b0;
    end else if (bus.Clear) begin
      pcount    <= '0;
      alarm     <= 1'b0;
      underflow <= 1'b0;
    end else if (up_p && !dn_p) begin
      if (pcount < CNT_MAX) begin
        pcount    <= pcount + CNT_W'(1);
        underflow <= 1'b0;
      end else begin
        alarm <= 1'b1;
      end
    end else if (dn_p && !up_p) begin
      if (pcount != '0) begin
        pcount <= pcount - CNT_W'(1);
        alarm  <= 1'b0;
      end else begin
        underflow <= 1'b1;
      end
    end
    // Simultaneous pulses cancel: nothing changes.
  end

  assign bus.Pcount           = pcount;
  assign bus.Empty_Flag       = (pcount == '0);
  assign bus.Full_Flag        = (pcount == CNT_MAX);
  assign bus.Almost_Full_Flag = (pcount >= CNT_AF);
  assign bus.Alarm_Flag       = alarm;
  assign bus.Underflow_Flag   = underflow;
  assign bus.Up_Pulse         = up_p;
  assign bus.Down_Pulse       = dn_p;

endmodule
`default_nettype wire

// File: tb/tb_queue_counter_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_queue_counter_param
//  Purpose  : Self-checking bench for queue_counter_param with a small
//             tick divider. Stimulus pushes the expected result of each
//             press; a monitor pops and compares whenever a pulse appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_queue_counter_param;

  logic clk;
  logic reset;

  queue_counter_param_if #(.CNT_W(3)) qif ();

  queue_counter_param #(
    .CNT_W      (3),
    .MAX_COUNT  (7),
    .ALMOST_FULL(6),
    .TICK_DIV   (4),
    .DEB_TICKS  (2)
  ) dut (
    .CLK  (clk),
    .reset(reset),
    .bus  (qif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       up;
    logic       dn;
    logic [2:0] cnt;
    logic       al;
    logic       un;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every pulse must match the oldest expectation; the counter
  // state is checked one cycle later, after the pulse has been applied.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && (qif.Up_Pulse || qif.Down_Pulse)) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: got up=%0b down=%0b expected none",
                   qif.Up_Pulse, qif.Down_Pulse);
        end else begin
          e = sb.pop_front();
          chk("up_pulse",   qif.Up_Pulse,   e.up);
          chk("down_pulse", qif.Down_Pulse, e.dn);
          @(negedge clk);
          chk("pcount",     qif.Pcount,           e.cnt);
          chk("alarm",      qif.Alarm_Flag,       e.al);
          chk("underflow",  qif.Underflow_Flag,   e.un);
          chk("empty",      qif.Empty_Flag,       e.cnt == 3'd0);
          chk("full",       qif.Full_Flag,        e.cnt == 3'd7);
          chk("almost",     qif.Almost_Full_Flag, e.cnt >= 3'd6);
        end
      end
    end
  end

  // One button press with its hand-computed outcome, then release and settle.
  task automatic press(input logic u, input logic d, input int hold,
                       input logic [2:0] c, input logic al, input logic un);
    exp_t e;
    e.up = u; e.dn = d; e.cnt = c; e.al = al; e.un = un;
    sb.push_back(e);
    qif.Up   = u;
    qif.Down = d;
    repeat (hold) @(negedge clk);
    qif.Up   = 1'b0;
    qif.Down = 1'b0;
    repeat (14) @(negedge clk);
    chk("press_drained", sb.size(), 0);
  endtask

  initial begin
    exp_t e;
    logic found;

    // 1. Reset held with Up pressed
    reset     = 1'b0;
    qif.Up    = 1'b1;
    qif.Down  = 1'b0;
    qif.Clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pcount",   qif.Pcount,           0);
    chk("rst_empty",    qif.Empty_Flag,       1);
    chk("rst_full",     qif.Full_Flag,        0);
    chk("rst_almost",   qif.Almost_Full_Flag, 0);
    chk("rst_alarm",    qif.Alarm_Flag,       0);
    chk("rst_under",    qif.Underflow_Flag,   0);
    chk("rst_up_pulse", qif.Up_Pulse,         0);
    chk("rst_dn_pulse", qif.Down_Pulse,       0);
    e.up = 1'b1; e.dn = 1'b0; e.cnt = 3'd1; e.al = 1'b0; e.un = 1'b0;
    sb.push_back(e);
    reset = 1'b1;
    repeat (14) @(negedge clk);
    chk("first_pulse_within_14", sb.size(), 0);
    qif.Up = 1'b0;
    repeat (14) @(negedge clk);

    // 2. Glitch rejection, then a 12-cycle hold giving one pulse
    qif.Up = 1'b1;
    repeat (3) @(negedge clk);
    qif.Up = 1'b0;
    repeat (14) @(negedge clk);
    chk("glitch_pcount", qif.Pcount, 1);
    press(1'b1, 1'b0, 12, 3'd2, 1'b0, 1'b0);

    // 3. Fill to full, reject at full, one decrement
    for (int c = 3; c <= 7; c++) press(1'b1, 1'b0, 14, 3'(c), 1'b0, 1'b0);
    press(1'b1, 1'b0, 14, 3'd7, 1'b1, 1'b0);
    press(1'b0, 1'b1, 14, 3'd6, 1'b0, 1'b0);

    // Plain clear back to empty
    @(negedge clk);
    qif.Clear = 1'b1;
    @(negedge clk);
    qif.Clear = 1'b0;
    chk("clear_pcount", qif.Pcount,     0);
    chk("clear_empty",  qif.Empty_Flag, 1);

    // 4. Underflow and its clearing by an increment
    press(1'b0, 1'b1, 14, 3'd0, 1'b0, 1'b1);
    press(1'b1, 1'b0, 14, 3'd1, 1'b0, 1'b0);

    // 5. Simultaneous presses at 3
    press(1'b1, 1'b0, 14, 3'd2, 1'b0, 1'b0);
    press(1'b1, 1'b0, 14, 3'd3, 1'b0, 1'b0);
    press(1'b1, 1'b1, 14, 3'd3, 1'b0, 1'b0);

    // 6. Refill, raise alarm, then clear coincident with an Up pulse
    for (int c = 4; c <= 7; c++) press(1'b1, 1'b0, 14, 3'(c), 1'b0, 1'b0);
    press(1'b1, 1'b0, 14, 3'd7, 1'b1, 1'b0);
    e.up = 1'b1; e.dn = 1'b0; e.cnt = 3'd0; e.al = 1'b0; e.un = 1'b0;
    sb.push_back(e);
    qif.Up = 1'b1;
    found  = 1'b0;
    for (int k = 0; k < 16 && !found; k++) begin
      @(negedge clk);
      if (qif.Up_Pulse) begin
        qif.Clear = 1'b1;
        found     = 1'b1;
      end
    end
    chk("clear_pulse_found", found, 1);
    @(negedge clk);
    qif.Clear = 1'b0;
    qif.Up    = 1'b0;
    repeat (14) @(negedge clk);
    chk("clear_drained", sb.size(), 0);

    // Asynchronous reset mid-debounce, away from any clock edge
    press(1'b1, 1'b0, 14, 3'd1, 1'b0, 1'b0);
    qif.Up = 1'b1;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_pcount", qif.Pcount,     0);
    chk("async_empty",  qif.Empty_Flag, 1);
    chk("async_pulse",  qif.Up_Pulse,   0);
    qif.Up = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("final_pcount", qif.Pcount, 0);
    chk("final_queue",  sb.size(),  0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/queue_counter_param.md
Name: queue_counter_param

Overview:
- Parametrised occupancy counter for the BBqM queue manager; next generation of the push-button up/down counter.
- Replaces the divided-clock scheme with a single-clock design: internal sampling tick (clock enable), per-button synchroniser, multi-tick debounce and one-shot edge detection.
- Adds configurable capacity, an almost-full threshold, a synchronous clear, sticky overflow/underflow alarms and event-pulse outputs.
- Feeds the display/alarm logic downstream.

Parameters:
- CNT_W, 3, width of Pcount.
- MAX_COUNT, 7, queue capacity; must be <= 2^CNT_W-1 and >= 1.
- ALMOST_FULL, 6, Almost_Full_Flag threshold; must be <= MAX_COUNT.
- TICK_DIV, 500000, CLK cycles per sampling tick; must be >= 2.
- DEB_TICKS, 4, consecutive ticks a new button level must hold before acceptance; must be >= 1.

Ports:
- CLK  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-low reset; 0 resets all state.
- Up  in  1  raw customer-arrival button, asynchronous, active-high.
- Down  in  1  raw customer-served button, asynchronous, active-high.
- Clear  in  1  synchronous clear, active-high; zeroes count and alarms.
- Pcount  out  CNT_W  current occupancy.
- Empty_Flag  out  1  Pcount == 0.
- Full_Flag  out  1  Pcount == MAX_COUNT.
- Almost_Full_Flag  out  1  Pcount >= ALMOST_FULL.
- Alarm_Flag  out  1  sticky: an Up event was rejected at full.
- Underflow_Flag  out  1  sticky: a Down event was rejected at empty.
- Up_Pulse  out  1  one-cycle pulse per accepted debounced Up press.
- Down_Pulse  out  1  one-cycle pulse per accepted debounced Down press.

Behaviour:
- Reset (reset=0, asynchronous):
  - Pcount=0, Empty_Flag=1, Full_Flag=0, Almost_Full_Flag=0.
  - Alarm_Flag=0, Underflow_Flag=0, Up_Pulse=0, Down_Pulse=0.
  - Tick divider, synchronisers, debounce counters and debounced levels all = 0.
  - Deassertion mid-press: the button is treated as newly pressed and must pass the full debounce.
- Tick: divider counts 0..TICK_DIV-1 and wraps; tick=1 for one cycle when divider==TICK_DIV-1.
- Synchroniser: two flops per button on every CLK edge.
- Debounce, per button, evaluated only on tick cycles:
  - sync == deb_level: stab_cnt <= 0.
  - sync != deb_level and stab_cnt == DEB_TICKS-1: deb_level <= sync, stab_cnt <= 0.
  - otherwise: stab_cnt++.
  - Any glitch shorter than DEB_TICKS ticks is ignored.
- Edge detect: a 0->1 transition of deb_level gives a registered X_Pulse high for exactly one CLK cycle, the cycle after deb_level rises. Release produces no pulse.
- Count update on the edge that samples the pulses, so Pcount changes 1 cycle after the pulse. Priority:
  1. Clear=1: Pcount<=0, Alarm_Flag<=0, Underflow_Flag<=0; pulses that cycle are ignored.
  2. Up_Pulse & Down_Pulse together: no change, no alarm.
  3. Up_Pulse only: if Pcount<MAX_COUNT then Pcount+1, else Pcount held and Alarm_Flag<=1.
  4. Down_Pulse only: if Pcount>0 then Pcount-1, else Pcount held and Underflow_Flag<=1.
- Alarm clearing: Alarm_Flag clears on the next successful decrement; Underflow_Flag clears on the next successful increment. A rejected event never clears the opposite flag.
- No wrap-around: Pcount saturates at 0 and MAX_COUNT.
- Empty_Flag, Full_Flag and Almost_Full_Flag are combinational decodes of the Pcount register, valid in the same cycle as Pcount.
- Latency from a clean press to Pcount change: 2 sync cycles + up to TICK_DIV + (DEB_TICKS-1)*TICK_DIV cycles + 2 cycles.

Test Plan:
Overrides for all scenarios: TICK_DIV=4, DEB_TICKS=2, MAX_COUNT=7, ALMOST_FULL=6.
1. Reset: hold reset=0 with Up=1 -> all outputs at reset values. Release, Up held -> exactly one Up_Pulse within 14 cycles, then Pcount=1, Empty_Flag=0.
2. Glitch rejection: Up high for 3 CLK cycles (< 1 tick of stability) -> no Up_Pulse, Pcount unchanged. Up held 12 cycles -> one pulse only.
3. Fill to full: 7 clean Up presses -> Pcount 1..7; Almost_Full_Flag rises at 6, Full_Flag at 7. 8th press -> Pcount=7, Alarm_Flag=1. One Down press -> Pcount=6, Alarm_Flag=0, Full_Flag=0.
4. Underflow: at Pcount=0, Down press -> Pcount=0, Underflow_Flag=1, Down_Pulse seen once. Up press -> Pcount=1, Underflow_Flag=0.
5. Simultaneous: Up and Down pressed on the same cycle at Pcount=3 -> both pulses in the same cycle, Pcount stays 3, both alarms stay 0.
6. Clear: at Pcount=7 with Alarm_Flag=1, Clear=1 for one cycle coincident with an Up_Pulse -> next cycle Pcount=0, Alarm_Flag=0, Empty_Flag=1. Assert reset asynchronously mid-debounce -> outputs reset immediately, with no clock edge needed.
